// File: rtl/add_unit_pkg.sv
// Shared types and elaboration helpers for the chunked add/subtract unit.
package add_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Number of CHUNK-wide slices in a WIDTH-wide operand.
   function automatic int num_chunks(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Counter width able to index every chunk; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // True when the operand width splits evenly into whole chunks.
   function automatic bit chunk_fits(input int width, input int chunk);
      return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit adder slice: sum and carry-out of a + b + cin.
module add_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   // One extra bit on every term captures the carry out of the slice.
   always_comb begin
      {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   end

endmodule

// File: rtl/multicycle_add_unit.sv
// Sequential add/subtract unit: one CHUNK-bit slice per clock through a
// registered carry, behind valid/ready handshakes on both sides.
module multicycle_add_unit
   import add_unit_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             c_in,
   input  logic             sign,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             c_out,
   output logic             OF,
   output logic             zero
);

   localparam int NCHUNK = num_chunks(WIDTH, CHUNK);
   localparam int CW     = cnt_width(NCHUNK);
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("multicycle_add_unit: WIDTH must be a non-zero multiple of CHUNK");
   end

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;        // B already inverted for subtract
   logic              carry_q, carry_d;
   logic              sign_q, sign_d;
   logic              sub_q, sub_d;
   logic [WIDTH-1:0]  sum_q, sum_d;    // working result, filled chunk by chunk
   logic [WIDTH-1:0]  out_q, out_d;    // published result, only moves on completion
   logic              c_out_q, c_out_d;
   logic              of_q, of_d;
   logic              zero_q, zero_d;

   logic [CHUNK-1:0]  a_chunk, b_chunk, chunk_sum;
   logic              chunk_cout;
   logic [WIDTH-1:0]  full_sum;

   // Select the operand slices addressed by the chunk counter.
   always_comb begin
      a_chunk = a_q[int'(cnt_q)*CHUNK +: CHUNK];
      b_chunk = b_q[int'(cnt_q)*CHUNK +: CHUNK];
   end

   add_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (a_chunk),
      .b    (b_chunk),
      .cin  (carry_q),
      .sum  (chunk_sum),
      .cout (chunk_cout)
   );

   // Working result with the current slice merged in.
   always_comb begin
      full_sum = sum_q;
      full_sum[int'(cnt_q)*CHUNK +: CHUNK] = chunk_sum;
   end

   // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
   always_comb begin
      // NOTE: every _d defaults to its _q so no path through the case leaves a
      // signal unassigned; without this the tool infers latches.
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sign_d  = sign_q;
      sub_d   = sub_q;
      sum_d   = sum_q;
      out_d   = out_q;
      c_out_d = c_out_q;
      of_d    = of_q;
      zero_d  = zero_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = A;
               b_d     = sub ? ~B : B;
               carry_d = c_in ^ sub;
               sign_d  = sign;
               sub_d   = sub;
               cnt_d   = '0;
               sum_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            sum_d   = full_sum;
            carry_d = chunk_cout;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = ST_DONE;
               out_d   = full_sum;
               c_out_d = chunk_cout;
               zero_d  = (full_sum == '0);
               of_d    = sign_q ? (~(a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (full_sum[WIDTH-1] ^ a_q[WIDTH-1]))
                                : (chunk_cout ^ sub_q);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; an async reset aborts any operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the datapath registers are reset along with the FSM so an
         // aborted operation leaves nothing visible on the outputs.
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sign_q  <= 1'b0;
         sub_q   <= 1'b0;
         sum_q   <= '0;
         out_q   <= '0;
         c_out_q <= 1'b0;
         of_q    <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // from before this edge, independent of statement order.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sign_q  <= sign_d;
         sub_q   <= sub_d;
         sum_q   <= sum_d;
         out_q   <= out_d;
         c_out_q <= c_out_d;
         of_q    <= of_d;
         zero_q  <= zero_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out       = out_q;
   assign c_out     = c_out_q;
   assign OF        = of_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_multicycle_add_unit.sv
// Self-checking bench: three configurations (16/4, 32/8, 16/16) driven with
// directed and random operations and compared with an arithmetic model.
module tb_multicycle_add_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] a_in, b_in;
   logic        c_in, sign, sub;
   logic [2:0]  in_valid, out_ready, in_ready, out_valid, c_out, of, zero;
   logic [15:0] out0, out2;
   logic [31:0] out1;
   logic [31:0] out_arr [3];

   assign out_arr[0] = {16'h0, out0};
   assign out_arr[1] = out1;
   assign out_arr[2] = {16'h0, out2};

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   multicycle_add_unit #(.WIDTH(16), .CHUNK(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .A(a_in[15:0]), .B(b_in[15:0]), .c_in(c_in), .sign(sign), .sub(sub),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out(out0),
      .c_out(c_out[0]), .OF(of[0]), .zero(zero[0]));

   multicycle_add_unit #(.WIDTH(32), .CHUNK(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .A(a_in), .B(b_in), .c_in(c_in), .sign(sign), .sub(sub),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out(out1),
      .c_out(c_out[1]), .OF(of[1]), .zero(zero[1]));

   multicycle_add_unit #(.WIDTH(16), .CHUNK(16)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .A(a_in[15:0]), .B(b_in[15:0]), .c_in(c_in), .sign(sign), .sub(sub),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out(out2),
      .c_out(c_out[2]), .OF(of[2]), .zero(zero[2]));

   function automatic int width_of(input int d);
      return (d == 1) ? 32 : 16;
   endfunction

   function automatic int chunks_of(input int d);
      return (d == 2) ? 1 : 4;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Plain-arithmetic reference: unsigned sum/difference, borrow, and signed range test.
   function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sg, input logic sb,
                                 output logic [31:0] o, output logic co, output logic ov,
                                 output logic z);
      longint mask, ua, ub, lci, full, sa, sbv, res, smax, smin;
      mask = (longint'(1) << w) - 1;
      ua   = longint'(a) & mask;
      ub   = longint'(b) & mask;
      lci  = ci ? 1 : 0;
      smax = (longint'(1) << (w - 1)) - 1;
      smin = -(longint'(1) << (w - 1));
      if (!sb) begin
         full = ua + ub + lci;
         co   = ((full >> w) & 1) != 0;
      end else begin
         full = ua - ub - lci;
         co   = (ua >= ub + lci);       // no borrow
      end
      o   = 32'(full & mask);
      sa  = (ua > smax) ? ua - (mask + 1) : ua;
      sbv = (ub > smax) ? ub - (mask + 1) : ub;
      res = sb ? (sa - sbv - lci) : (sa + sbv + lci);
      ov  = sg ? ((res > smax) || (res < smin)) : (co ^ sb);
      z   = (o == 32'd0);
   endfunction

   // Called on the negedge following the accept edge; counts edges to out_valid.
   task automatic wait_result(input int d, input logic [31:0] a, input logic [31:0] b,
                              input logic ci, input logic sg, input logic sb, input string tag);
      int lat;
      logic [31:0] eo;
      logic eco, eov, ez;
      lat = 0;
      while (!out_valid[d] && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      model(width_of(d), a, b, ci, sg, sb, eo, eco, eov, ez);
      check({tag, ":latency"}, lat, chunks_of(d));
      check({tag, ":out"}, out_arr[d], eo);
      check({tag, ":c_out"}, c_out[d], eco);
      check({tag, ":OF"}, of[d], eov);
      check({tag, ":zero"}, zero[d], ez);
      if (out_ready[d]) begin
         @(negedge clk);
         check({tag, ":pulse"}, out_valid[d], 1'b0);
         check({tag, ":hold"}, out_arr[d], eo);
      end
   endtask

   task automatic do_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sg, input logic sb, input string tag);
      int budget;
      @(negedge clk);
      budget = 0;
      while (!in_ready[d] && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      check({tag, ":in_ready"}, in_ready[d], 1'b1);
      a_in = a; b_in = b; c_in = ci; sign = sg; sub = sb;
      in_valid[d] = 1'b1;
      @(negedge clk);
      in_valid[d] = 1'b0;
      // Scramble every operand input while busy; only the accept edge may count.
      a_in = $urandom; b_in = $urandom;
      c_in = 1'($urandom); sign = 1'($urandom); sub = 1'($urandom);
      wait_result(d, a, b, ci, sg, sb, tag);
   endtask

   task automatic expect_outs(input int d, input logic [31:0] o, input logic co,
                              input logic ov, input logic z, input string tag);
      check({tag, ":k_out"}, out_arr[d], o);
      check({tag, ":k_c_out"}, c_out[d], co);
      check({tag, ":k_OF"}, of[d], ov);
      check({tag, ":k_zero"}, zero[d], z);
   endtask

   initial begin
      in_valid = '0; out_ready = '1;
      a_in = '0; b_in = '0; c_in = 1'b0; sign = 1'b0; sub = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check("rst:in_ready", in_ready[d], 1'b1);
         check("rst:out_valid", out_valid[d], 1'b0);
         check("rst:out", out_arr[d], 32'h0);
         check("rst:flags", {c_out[d], of[d], zero[d]}, 3'b000);
      end
      rst_n = 1'b1;

      // Directed cases on the 16/4 instance.
      do_op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b1, 1'b0, "sadd");
      expect_outs(0, 32'h8000, 1'b0, 1'b1, 1'b0, "sadd");
      do_op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 1'b0, "uadd");
      expect_outs(0, 32'h0000, 1'b1, 1'b1, 1'b1, "uadd");
      do_op(0, 32'h0003, 32'h0005, 1'b0, 1'b0, 1'b1, "usub");
      expect_outs(0, 32'hFFFE, 1'b0, 1'b1, 1'b0, "usub");
      do_op(0, 32'h0003, 32'h0005, 1'b0, 1'b1, 1'b1, "ssub");
      expect_outs(0, 32'hFFFE, 1'b0, 1'b0, 1'b0, "ssub");
      do_op(0, 32'h0003, 32'h0005, 1'b1, 1'b0, 1'b1, "usub_b");
      expect_outs(0, 32'hFFFD, 1'b0, 1'b1, 1'b0, "usub_b");
      do_op(0, 32'h8000, 32'h0001, 1'b0, 1'b1, 1'b1, "sunder");
      expect_outs(0, 32'h7FFF, 1'b1, 1'b1, 1'b0, "sunder");

      // Backpressure: result held, new request ignored until out_ready.
      out_ready[0] = 1'b0;
      do_op(0, 32'h1234, 32'h0F0F, 1'b0, 1'b0, 1'b0, "bp");
      a_in = 32'h0001; b_in = 32'h0002; c_in = 1'b0; sign = 1'b0; sub = 1'b0;
      in_valid[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp:out_valid", out_valid[0], 1'b1);
         check("bp:in_ready", in_ready[0], 1'b0);
         check("bp:out", out_arr[0], 32'h2143);
         check("bp:flags", {c_out[0], of[0], zero[0]}, 3'b000);
      end
      out_ready[0] = 1'b1;
      @(negedge clk);
      check("bp:release_valid", out_valid[0], 1'b0);
      check("bp:release_ready", in_ready[0], 1'b1);
      check("bp:release_out", out_arr[0], 32'h2143);
      @(negedge clk);
      in_valid[0] = 1'b0;
      wait_result(0, 32'h0001, 32'h0002, 1'b0, 1'b0, 1'b0, "bp_next");

      // Reset abort after two BUSY edges; previous result 0x0003 is non-zero.
      @(negedge clk);
      a_in = 32'h0F0F; b_in = 32'h0101; c_in = 1'b1; sign = 1'b0; sub = 1'b0;
      in_valid[0] = 1'b1;
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort:out", out_arr[0], 32'h0);
      check("abort:flags", {c_out[0], of[0], zero[0]}, 3'b000);
      check("abort:out_valid", out_valid[0], 1'b0);
      check("abort:in_ready", in_ready[0], 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1'b1;
         end
         check("abort:no_result", seen, 1'b0);
      end
      check("abort:ready_after", in_ready[0], 1'b1);

      // Random operations on the 32/8 and 16/16 instances.
      for (int i = 0; i < 2000; i++) begin
         do_op((i % 2 == 0) ? 1 : 2, $urandom, $urandom, 1'($urandom),
               1'($urandom), 1'($urandom), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_add_unit.md
Name: multicycle_add_unit

Overview:
- Parametrised, sequential successor to the combinational 16-bit ALU adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, using a registered carry between chunks.
- Reports carry-out, signed/unsigned overflow and zero.
- Sits behind a valid/ready handshake. Used where a full-width single-cycle carry chain would break timing, or where area matters more than throughput.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock; CHUNK == WIDTH gives a single BUSY cycle.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  unit can accept operands.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- c_in  in  1  carry-in (add) / borrow-in (sub).
- sign  in  1  1 = signed overflow rule, 0 = unsigned.
- sub  in  1  1 = A - B, 0 = A + B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  result.
- c_out  out  1  raw carry out of the MSB.
- OF  out  1  overflow per sign/sub rules.
- zero  out  1  out == 0.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state IDLE, in_ready=1, out_valid=0, out=0, c_out=0, OF=0, zero=0; chunk counter and internal registers cleared.
- NCHUNK = WIDTH/CHUNK.
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_ready=1. On in_valid, capture the operands and go to BUSY (the accept edge).
  - Captured at accept: A; Beff = sub ? ~B : B; carry = c_in ^ sub; sign; sub; counter=0.
  - sub=1 with c_in=0 computes A-B; sub=1 with c_in=1 computes A-B-1.
  - BUSY: in_ready=0. Each edge adds chunk[cnt] of A, Beff and carry, writes that result chunk, updates carry, and increments cnt (LSB chunk first).
  - BUSY exit: on the edge that processes chunk NCHUNK-1, go to DONE and register c_out, OF and zero.
  - DONE: out_valid=1, in_ready=0. When out_ready=1, go to IDLE and drop out_valid.
- Latency: out_valid rises exactly NCHUNK edges after the accept edge.
- Throughput: at most one operation per NCHUNK+2 cycles. There is no overlap; in_ready is high only in IDLE.
- Flag rules:
  - c_out = final carry out of the MSB, unmodified.
  - Signed overflow (sign=1): OF = ~(A[W-1]^Beff[W-1]) & (out[W-1]^A[W-1]).
  - Unsigned overflow (sign=0): OF = c_out ^ sub (carry on add, borrow on sub).
  - zero = (out == 0).
- Stability:
  - out, c_out, OF and zero hold stable from the out_valid rise until the next completion, including after the handshake.
  - A, B, c_in, sign and sub are ignored except at the accept edge.
- Backpressure: DONE holds indefinitely while out_ready=0; in_valid is ignored in this state.
- out_ready held high: out_valid is a one-cycle pulse.
- Reset mid-operation (BUSY or DONE): the operation is aborted, all outputs return to reset values immediately, and no result is produced.
- Changing the sign/sub inputs during BUSY has no effect.

Decomposition:
- Package add_unit_pkg:
  - FSM state encoding (IDLE/BUSY/DONE).
  - Functions for NCHUNK and counter width (clog2, minimum 1).
  - Elaboration check that WIDTH % CHUNK == 0.
- Sub-module add_chunk:
  - Combinational CHUNK-bit adder: a, b, cin -> sum, cout.
  - Instantiated once and muxed by the chunk counter.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- Signed add: A=0x7FFF, B=0x0001, sign=1, sub=0, c_in=0 -> out=0x8000, c_out=0, OF=1, zero=0; out_valid 4 edges after accept.
- Unsigned add: A=0xFFFF, B=0x0001, sign=0, sub=0 -> out=0x0000, c_out=1, OF=1, zero=1.
- Subtract 0x0003 - 0x0005, sub=1, c_in=0:
  - sign=0 -> out=0xFFFE, c_out=0, OF=1.
  - Same with sign=1 -> OF=0.
  - sign=0 with c_in=1 -> out=0xFFFD.
- Signed subtract underflow: A=0x8000, B=0x0001, sub=1, sign=1, c_in=0 -> out=0x7FFF, OF=1, c_out=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid, with in_valid=1 and new operands -> out/flags constant, in_ready=0, no new accept; out_ready=1 -> IDLE the next cycle, then the new operation is accepted.
- Reset abort: assert rst_n=0 after 2 BUSY edges -> outputs zero immediately and in_ready=1 after release.
- Randomised check: WIDTH=32, CHUNK=8, and WIDTH=CHUNK=16, 1000 random ops vs a behavioural model.
